// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: framed byte stream to 32-bit words.
// Holds the core in reset until a frame with a good checksum is written.
module imem_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int MEM_WORDS  = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  rx_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic [31:0]           mem_wdata,
    output logic                  core_rst,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [2:0] {
        IDLE, CNT_LO, CNT_HI, DATA, CHECK, DONE, ERR
    } state_t;

    localparam logic [7:0]  SYNC  = 8'hA5;
    localparam logic [16:0] MAX_N = 17'(MEM_WORDS);

    state_t      state;
    logic [15:0] count;
    logic [15:0] word_idx;
    logic [1:0]  byte_idx;
    logic [23:0] wbuf;
    logic [7:0]  acc;
    logic        take;
    logic [15:0] n_next;

    assign take   = rx_valid && rx_ready;
    assign n_next = {rx_data, count[7:0]};

    always_comb begin
        rx_ready = 1'b0;
        busy     = 1'b0;
        unique case (state)
            IDLE:                       rx_ready = 1'b1;
            CNT_LO, CNT_HI, DATA, CHECK: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            word_idx  <= '0;
            byte_idx  <= '0;
            wbuf      <= '0;
            acc       <= '0;
            mem_we    <= 1'b0;
            mem_waddr <= '0;
            mem_wdata <= '0;
            core_rst  <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            if (take) begin
                unique case (state)
                    IDLE: begin
                        if (rx_data == SYNC)
                            state <= CNT_LO;
                    end
                    CNT_LO: begin
                        count[7:0] <= rx_data;
                        state      <= CNT_HI;
                    end
                    CNT_HI: begin
                        count    <= n_next;
                        word_idx <= '0;
                        byte_idx <= '0;
                        acc      <= '0;
                        if ({1'b0, n_next} > MAX_N) begin
                            err   <= 1'b1;
                            state <= ERR;
                        end else if (n_next == 16'd0) begin
                            state <= CHECK;
                        end else begin
                            state <= DATA;
                        end
                    end
                    DATA: begin
                        acc      <= acc ^ rx_data;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            mem_we    <= 1'b1;
                            mem_waddr <= word_idx[ADDR_WIDTH-1:0];
                            mem_wdata <= {rx_data, wbuf};
                            word_idx  <= word_idx + 16'd1;
                            if (word_idx == count - 16'd1)
                                state <= CHECK;
                        end else begin
                            wbuf[byte_idx*8 +: 8] <= rx_data;
                        end
                    end
                    CHECK: begin
                        if (rx_data == acc) begin
                            done     <= 1'b1;
                            core_rst <= 1'b0;
                            state    <= DONE;
                        end else begin
                            err   <= 1'b1;
                            state <= ERR;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Streaming byte-to-word writer that fills the core's instruction memory at boot, so programs load at run time rather than through a simulation-time file preload. It accepts a framed byte stream on a valid/ready interface and assembles little-endian 32-bit words. It writes those words sequentially into the instruction-memory write port. It holds the core in reset until a load completes with a good checksum.

Parameters:
ADDR_WIDTH, 8, word-address width of the instruction-memory write port.
MEM_WORDS, 256, capacity in words; a frame declaring more words than this is rejected.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous, active-high reset.
rx_valid  in  1  byte-stream valid.
rx_data  in  8  byte-stream data.
rx_ready  out  1  loader can accept a byte; a byte is accepted on a cycle with rx_valid && rx_ready.
mem_we  out  1  instruction-memory write enable, one-cycle pulse per word.
mem_waddr  out  ADDR_WIDTH  word address for the write.
mem_wdata  out  32  write data.
core_rst  out  1  reset to the riscv core; high until a successful load.
busy  out  1  a frame is in progress (any state other than IDLE, DONE, ERR).
done  out  1  sticky; load succeeded.
err  out  1  sticky; load failed.

Behaviour:
- Clocking and reset: single clock; rst is synchronous and active-high.
- Reset values: state=IDLE, mem_we=0, mem_waddr=0, mem_wdata=0, core_rst=1, busy=0, done=0, err=0.
- rx_ready is decoded from state: 1 in IDLE, CNT_LO, CNT_HI, DATA and CHECK; 0 in DONE and ERR.
- Frame format: sync byte 0xA5, count_lo, count_hi (word count N, 16-bit), 4*N payload bytes (least significant byte first), one checksum byte.
- The checksum is the XOR of all payload bytes; header bytes are excluded.
- FSM transitions (evaluated on accepted bytes only):
  - IDLE: byte 0xA5 goes to CNT_LO; any other byte is discarded and the FSM stays in IDLE.
  - CNT_LO: latch count[7:0], go to CNT_HI.
  - CNT_HI: latch count[15:8].
    - N > MEM_WORDS goes to ERR.
    - N == 0 goes to CHECK.
    - Otherwise clear the word index, byte index and XOR accumulator, then go to DATA.
  - DATA: shift the byte into lane byte_idx and XOR it into the accumulator.
    - On byte_idx==3, register mem_we=1, mem_waddr=word_idx and mem_wdata={b3,b2,b1,b0}, all visible the cycle after the 4th byte is accepted, for exactly one cycle.
    - After that 4th byte, word_idx increments, byte_idx wraps to 0, and when word_idx==N-1 the FSM goes to CHECK.
  - CHECK: a byte equal to the accumulator goes to DONE; a mismatch goes to ERR.
  - DONE: done=1 and core_rst=0, both registered (first high/low the cycle after the checksum byte is accepted). Stays in DONE until rst.
  - ERR: err=1 and core_rst stays 1. Stays in ERR until rst.
- Gaps (rx_valid=0) in any state: hold all state; mem_we stays 0.
- Exactly one mem_we pulse per word; never two in consecutive cycles (4 accepted bytes minimum separate them).
- Word indices wrap is impossible: N ≤ MEM_WORDS is checked before DATA is entered.
- rst mid-frame: return to reset values the next edge. Words already written stay in memory; the next frame overwrites them from address 0.
- done and err are never high together.

Test Plan:
1. rst, then bytes A5 02 00 13 00 00 00 93 00 50 00 D0 back-to-back.
   - Required: mem_we pulse with addr 0 / 0x00000013, then addr 1 / 0x00500093.
   - Required: done=1 and core_rst=0 one cycle after D0; rx_ready=0 afterwards.
2. Same frame with checksum D1.
   - Required: err=1, done=0, core_rst stays 1, rx_ready=0.
   - Required: both words are still written.
3. Prefix 00 FF 5A before the frame from test 1.
   - Required: prefix bytes are ignored and busy stays 0 until A5; the result is identical to test 1.
4. A5 00 00 00.
   - Required: no mem_we pulse; done=1.
5. A5 01 01 (N=257, MEM_WORDS=256).
   - Required: err=1 the cycle after count_hi is accepted; no mem_we pulse.
6. Frame from test 1 with rx_valid toggling 1/0 every cycle, then rst asserted mid-DATA, then the full frame resent.
   - Required: writes land at the same addresses and data; after rst core_rst=1, done=0, err=0.
   - Required: the resent load completes with done=1.
